// File: rtl/fifo_sync_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_sync_param_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int FIFO_DEFAULT_WIDTH = 32;
  localparam int FIFO_DEFAULT_DEPTH = 16;

  // Pointer width for a given depth; a depth of 1 still needs one address bit.
  function automatic int fifo_ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic bit fifo_is_pow2(input int d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_sync_param_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_sync_param_ram
  import fifo_sync_param_pkg::*;
#(
  parameter int WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH = FIFO_DEFAULT_DEPTH,
  parameter int PW    = fifo_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write port; contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with level flags, sticky error flags, flush and
// selectable standard or first-word-fall-through read.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH    = FIFO_DEFAULT_DEPTH,
  parameter int FWFT     = FIFO_MODE_STD,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_ZERO = LW'(1'b0);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

  if (!fifo_is_pow2(DEPTH) || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
      AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_param_check
    $error("fifo_sync_param: DEPTH must be a power of two >= 2 and AF/AE levels in range");
  end

  logic [PW-1:0]    w_ptr_r, r_ptr_r;
  logic [LW-1:0]    level_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r;
  logic             overflow_r, underflow_r;

  logic             rd_acc_s, wr_acc_s, full_s, empty_s;
  logic [LW-1:0]    level_nxt_s;
  logic [PW-1:0]    raddr_s;
  logic [WIDTH-1:0] ram_rdata_s;
  logic [WIDTH-1:0] rd_data_nxt_s;

  fifo_sync_param_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_ram (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (w_ptr_r),
    .wdata (wr_data),
    .raddr (raddr_s),
    .rdata (ram_rdata_s)
  );

  // Accept decisions and next level; a read frees the slot a full write needs.
  always_comb begin
    full_s   = (level_r == LVL_FULL);
    empty_s  = (level_r == LVL_ZERO);
    rd_acc_s = rd_en & ~empty_s;
    wr_acc_s = wr_en & (~full_s | rd_acc_s);
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Output register source; FWFT preloads the word that will be head next cycle.
  always_comb begin
    rd_data_nxt_s = rd_data_r;
    if (FWFT == FIFO_MODE_FWFT) begin
      raddr_s = r_ptr_r + PTR_ONE;
      if (wr_acc_s && (empty_s || (rd_acc_s && level_r == LVL_ONE))) begin
        rd_data_nxt_s = wr_data;
      end else if (rd_acc_s && level_r > LVL_ONE) begin
        rd_data_nxt_s = ram_rdata_s;
      end else begin
        rd_data_nxt_s = rd_data_r;
      end
    end else begin
      raddr_s = r_ptr_r;
      if (rd_acc_s) begin
        rd_data_nxt_s = ram_rdata_s;
      end else begin
        rd_data_nxt_s = rd_data_r;
      end
    end
  end

  // Pointer, level, output and sticky-flag state; rst outranks flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_r     <= PW'(1'b0);
      r_ptr_r     <= PW'(1'b0);
      level_r     <= LVL_ZERO;
      rd_data_r   <= WIDTH'(1'b0);
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      w_ptr_r     <= PW'(1'b0);
      r_ptr_r     <= PW'(1'b0);
      level_r     <= LVL_ZERO;
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) w_ptr_r <= w_ptr_r + PTR_ONE;
      if (rd_acc_s) r_ptr_r <= r_ptr_r + PTR_ONE;
      level_r     <= level_nxt_s;
      rd_data_r   <= rd_data_nxt_s;
      rd_valid_r  <= rd_acc_s;
      overflow_r  <= overflow_r  | (wr_en & ~wr_acc_s);
      underflow_r <= underflow_r | (rd_en & ~rd_acc_s);
    end
  end

  assign rd_data      = rd_data_r;
  assign rd_valid     = (FWFT == FIFO_MODE_FWFT) ? (level_r != LVL_ZERO) : rd_valid_r;
  assign full         = (level_r == LVL_FULL);
  assign empty        = (level_r == LVL_ZERO);
  assign almost_full  = (level_r >= LVL_AF);
  assign almost_empty = (level_r <= LVL_AE);
  assign level        = level_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench: standard-mode instance plus an FWFT instance on shared inputs.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] wr_data = 32'h0;

  logic [31:0] rd_data, f_rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic        f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0]  level, f_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(32), .DEPTH(4), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow));

  fifo_sync_param #(.WIDTH(32), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) dut_f (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_udf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin bad++;
      $display("FAIL reset_flags got=%b exp=1010", {empty, full, almost_empty, almost_full}); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if ({rd_valid, overflow, underflow} !== 3'b000) begin bad++;
      $display("FAIL reset_valid_sticky got=%b exp=000", {rd_valid, overflow, underflow}); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++; if ({f_rd_valid, f_empty} !== 2'b01) begin bad++;
      $display("FAIL reset_fwft got=%b exp=01", {f_rd_valid, f_empty}); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(32'hA0 + 32'(i));
      total++; if (level !== 3'(i + 1)) begin bad++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
      total++; if (almost_full !== (i >= 2)) begin bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, i >= 2); end
      total++; if (full !== (i == 3)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 3); end
      total++; if (almost_empty !== (i == 0)) begin bad++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, i == 0); end
    end
    for (int i = 0; i < 4; i++) begin
      pop();
      total++; if ({rd_valid, rd_data} !== {1'b1, 32'hA0 + 32'(i)}) begin bad++;
        $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, 32'hA0 + 32'(i)); end
      total++; if (level !== 3'(3 - i)) begin bad++; $display("FAIL drain_level[%0d] got=%0d exp=%0d", i, level, 3 - i); end
    end
    tick();
    total++; if ({rd_valid, empty, rd_data} !== {2'b01, 32'hA3}) begin bad++;
      $display("FAIL drain_idle got=%b%b/%h exp=01/a3", rd_valid, empty, rd_data); end
  endtask

  task automatic test_overflow_underflow();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    push(32'hFF);
    total++; if ({overflow, level} !== {1'b1, 3'd4}) begin bad++;
      $display("FAIL ovf_set got=%b/%0d exp=1/4", overflow, level); end
    pop();
    total++; if (rd_data !== 32'hA0) begin bad++; $display("FAIL ovf_head got=%h exp=a0", rd_data); end
    pop(); pop(); pop();
    total++; if (rd_data !== 32'hA3) begin bad++; $display("FAIL ovf_tail got=%h exp=a3", rd_data); end
    pop();
    total++; if ({underflow, rd_valid, rd_data} !== {2'b10, 32'hA3}) begin bad++;
      $display("FAIL udf_set got=%b%b/%h exp=10/a3", underflow, rd_valid, rd_data); end
    tick(); tick();
    total++; if ({overflow, underflow} !== 2'b11) begin bad++;
      $display("FAIL sticky_hold got=%b exp=11", {overflow, underflow}); end
    flush = 1'b1; tick(); flush = 1'b0;
    total++; if ({overflow, underflow, empty} !== 3'b001) begin bad++;
      $display("FAIL sticky_flush got=%b exp=001", {overflow, underflow, empty}); end
  endtask

  task automatic test_full_rdwr();
    logic [31:0] exp_q [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hB4};
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hB4; tick(); wr_en = 1'b0; rd_en = 1'b0;
    total++; if ({rd_valid, rd_data, level, overflow} !== {1'b1, 32'hA0, 3'd4, 1'b0}) begin bad++;
      $display("FAIL full_rdwr got=%b/%h/%0d/%b exp=1/a0/4/0", rd_valid, rd_data, level, overflow); end
    for (int i = 0; i < 4; i++) begin
      pop();
      total++; if (rd_data !== exp_q[i]) begin bad++; $display("FAIL full_rdwr_drain[%0d] got=%h exp=%h", i, rd_data, exp_q[i]); end
    end
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hC5; tick(); wr_en = 1'b0; rd_en = 1'b0;
    total++; if ({underflow, level, rd_valid} !== {1'b1, 3'd1, 1'b0}) begin bad++;
      $display("FAIL empty_rdwr got=%b/%0d/%b exp=1/1/0", underflow, level, rd_valid); end
    pop();
    total++; if (rd_data !== 32'hC5) begin bad++; $display("FAIL empty_rdwr_data got=%h exp=c5", rd_data); end
  endtask

  task automatic test_wrap();
    do_reset();
    push(32'h0FF);
    for (int i = 0; i < 10; i++) begin
      push(32'h100 + 32'(i));
      total++; if (level !== 3'd2) begin bad++; $display("FAIL wrap_level[%0d] got=%0d exp=2", i, level); end
      pop();
      total++; if (rd_data !== ((i == 0) ? 32'h0FF : 32'h100 + 32'(i - 1))) begin bad++;
        $display("FAIL wrap_data[%0d] got=%h", i, rd_data); end
    end
    pop();
    total++; if ({rd_data, empty} !== {32'h109, 1'b1}) begin bad++;
      $display("FAIL wrap_last got=%h/%b exp=109/1", rd_data, empty); end
  endtask

  task automatic test_fwft();
    do_reset();
    push(32'hC0);
    total++; if ({f_rd_valid, f_rd_data} !== {1'b1, 32'hC0}) begin bad++;
      $display("FAIL fwft_first got=%b/%h exp=1/c0", f_rd_valid, f_rd_data); end
    push(32'hC1);
    total++; if ({f_rd_data, f_level} !== {32'hC0, 3'd2}) begin bad++;
      $display("FAIL fwft_hold got=%h/%0d exp=c0/2", f_rd_data, f_level); end
    pop();
    total++; if ({f_rd_valid, f_rd_data} !== {1'b1, 32'hC1}) begin bad++;
      $display("FAIL fwft_next got=%b/%h exp=1/c1", f_rd_valid, f_rd_data); end
    pop();
    total++; if ({f_rd_valid, f_empty, f_rd_data} !== {2'b01, 32'hC1}) begin bad++;
      $display("FAIL fwft_drain got=%b%b/%h exp=01/c1", f_rd_valid, f_empty, f_rd_data); end
    push(32'hC2);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hC3; tick(); wr_en = 1'b0; rd_en = 1'b0;
    total++; if ({f_rd_valid, f_rd_data, f_level} !== {1'b1, 32'hC3, 3'd1}) begin bad++;
      $display("FAIL fwft_rdwr_l1 got=%b/%h/%0d exp=1/c3/1", f_rd_valid, f_rd_data, f_level); end
  endtask

  task automatic test_rst_flush();
    do_reset();
    pop();
    push(32'hD0); push(32'hD1); pop(); push(32'hD2); push(32'hD3);
    total++; if ({level, underflow, rd_data} !== {3'd3, 1'b1, 32'hD0}) begin bad++;
      $display("FAIL pre_flush got=%0d/%b/%h exp=3/1/d0", level, underflow, rd_data); end
    flush = 1'b1; tick(); flush = 1'b0;
    total++; if ({level, empty, underflow, overflow, rd_valid, rd_data} !== {3'd0, 4'b1000, 32'hD0}) begin bad++;
      $display("FAIL flush got=%0d/%b%b%b%b/%h exp=0/1000/d0", level, empty, underflow, overflow, rd_valid, rd_data); end
    push(32'hE0); push(32'hE1); push(32'hE2); pop(); push(32'hE3);
    rst = 1'b1; flush = 1'b1; tick(); rst = 1'b0; flush = 1'b0;
    total++; if ({level, empty, rd_valid, rd_data} !== {3'd0, 2'b10, 32'h0}) begin bad++;
      $display("FAIL rst_flush got=%0d/%b%b/%h exp=0/10/0", level, empty, rd_valid, rd_data); end
    push(32'hE4);
    total++; if (f_rd_data !== 32'hE4) begin bad++; $display("FAIL post_rst_fwft got=%h exp=e4", f_rd_data); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_full_rdwr();
    test_wrap();
    test_fwft();
    test_rst_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
